vga_fb_pixel_sink: RTL and testbench

- Consumer stage directly downstream of the frame-buffer pixel stream generator, in the same clk domain.
- Buffers streamed pixels (color plus hsync/vsync) in a small internal FIFO and throttles the generator through its enable input.
- Emits exactly one pixel to the VGA output pins on every pixel_ce strobe, giving a fixed pixel rate derived from clk.
- Flags underflow and overflow so board bring-up can detect rate mismatch.

---
 rtl/vga_fb_pixel_sink.sv | 147 ++++++++++++++
 tb/tb_vga_fb_pixel_sink.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_pixel_sink.sv
// Pixel sink for the frame-buffer stream: buffers pixels in a small FIFO, throttles the
// generator through s_enable and emits one registered VGA pixel per pixel_ce strobe.
module vga_fb_pixel_sink #(
  parameter int PIXEL_BITS     = 12,
  parameter int FIFO_ADDR_BITS = 4,
  parameter int ENABLE_SLACK   = 6,
  parameter int START_LEVEL    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pixel_ce,
  input  logic                    s_valid,
  input  logic                    s_hsync,
  input  logic                    s_vsync,
  input  logic [PIXEL_BITS-1:0]   s_color,
  output logic                    s_enable,
  output logic                    vga_hsync,
  output logic                    vga_vsync,
  output logic [PIXEL_BITS/3-1:0] vga_red,
  output logic [PIXEL_BITS/3-1:0] vga_green,
  output logic [PIXEL_BITS/3-1:0] vga_blue,
  output logic                    running,
  output logic                    underflow,
  output logic                    overflow
);

  localparam int DEPTH       = 2 ** FIFO_ADDR_BITS;
  localparam int COLOR_BITS  = PIXEL_BITS / 3;
  localparam int ENTRY_BITS  = PIXEL_BITS + 2;

  localparam logic [FIFO_ADDR_BITS:0]   CNT_ONE      = {{FIFO_ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [FIFO_ADDR_BITS-1:0] PTR_ONE      = {{(FIFO_ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [FIFO_ADDR_BITS:0]   CNT_FULL     = {1'b1, {FIFO_ADDR_BITS{1'b0}}};
  localparam logic [FIFO_ADDR_BITS:0]   ENABLE_LIMIT = CNT_FULL - ENABLE_SLACK[FIFO_ADDR_BITS:0];
  localparam logic [FIFO_ADDR_BITS:0]   START_CNT    = START_LEVEL[FIFO_ADDR_BITS:0];

  localparam logic STATE_FILL = 1'b0;
  localparam logic STATE_RUN  = 1'b1;

  // FIFO storage and bookkeeping
  logic [ENTRY_BITS-1:0]     mem_q [DEPTH];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_ADDR_BITS:0]   count_q, count_d;
  logic                      full, empty, push, pop;

  logic                      state_q, state_d;
  logic                      s_enable_q, s_enable_d;
  logic                      rst_dly_q;

  logic                      hsync_q, hsync_d;
  logic                      vsync_q, vsync_d;
  logic [PIXEL_BITS-1:0]     color_q, color_d;
  logic                      underflow_q, underflow_d;
  logic                      overflow_q, overflow_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    full        = (count_q == CNT_FULL);
    empty       = (count_q == '0);
    pop         = pixel_ce && (state_q == STATE_RUN) && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    push        = s_valid && (!full || pop);

    wr_ptr_d    = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d     = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end

    state_d = state_q;
    if ((state_q == STATE_FILL) && (count_q >= START_CNT)) begin
      state_d = STATE_RUN;
    end

    // Enable is held low for one extra cycle after reset via rst_dly_q.
    s_enable_d  = !rst_dly_q && (count_d <= ENABLE_LIMIT);

    hsync_d     = hsync_q;
    vsync_d     = vsync_q;
    color_d     = color_q;
    underflow_d = underflow_q;
    overflow_d  = overflow_q | (s_valid && full && !pop);
    if (pixel_ce) begin
      if (state_q == STATE_RUN) begin
        if (!empty) begin
          {hsync_d, vsync_d, color_d} = mem_q[rd_ptr_q];
        end else begin
          color_d     = '0;
          underflow_d = 1'b1;
        end
      end else begin
        color_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= STATE_FILL;
      s_enable_q  <= 1'b0;
      rst_dly_q   <= 1'b1;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      color_q     <= '0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      s_enable_q  <= s_enable_d;
      rst_dly_q   <= 1'b0;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      color_q     <= color_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: the storage array is not reset; occupancy and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= {s_hsync, s_vsync, s_color};
    end
  end

  assign s_enable  = s_enable_q;
  assign vga_hsync = hsync_q;
  assign vga_vsync = vsync_q;
  assign vga_red   = color_q[PIXEL_BITS-1 -: COLOR_BITS];
  assign vga_green = color_q[2*COLOR_BITS-1 -: COLOR_BITS];
  assign vga_blue  = color_q[COLOR_BITS-1:0];
  assign running   = (state_q == STATE_RUN);
  assign underflow = underflow_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_vga_fb_pixel_sink.sv
// Directed bench for vga_fb_pixel_sink: reset, priming, full push+pop, overflow,
// drain into underflow, recovery and upstream throttling with a 3-cycle enable latency.
module tb_vga_fb_pixel_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic        pixel_ce;
  logic        s_valid;
  logic        s_hsync;
  logic        s_vsync;
  logic [11:0] s_color;
  logic        s_enable;
  logic        vga_hsync;
  logic        vga_vsync;
  logic [3:0]  vga_red;
  logic [3:0]  vga_green;
  logic [3:0]  vga_blue;
  logic        running;
  logic        underflow;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [13:0] out_v;
  assign out_v = {vga_hsync, vga_vsync, vga_red, vga_green, vga_blue};

  vga_fb_pixel_sink #(
    .PIXEL_BITS    (12),
    .FIFO_ADDR_BITS(4),
    .ENABLE_SLACK  (6),
    .START_LEVEL   (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pixel_ce (pixel_ce),
    .s_valid  (s_valid),
    .s_hsync  (s_hsync),
    .s_vsync  (s_vsync),
    .s_color  (s_color),
    .s_enable (s_enable),
    .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync),
    .vga_red  (vga_red),
    .vga_green(vga_green),
    .vga_blue (vga_blue),
    .running  (running),
    .underflow(underflow),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  // Entry {hsync, vsync, color}; colors are unique for i < 24.
  function automatic logic [13:0] pix(input int i);
    logic [4:0] b;
    b = 5'(i);
    return {~b[0], b[4] | b[1], 12'((i + 1) * 167)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push_px(input logic [13:0] e, input logic ce);
    s_valid  = 1'b1;
    {s_hsync, s_vsync, s_color} = e;
    pixel_ce = ce;
    tick();
    s_valid  = 1'b0;
    pixel_ce = 1'b0;
    {s_hsync, s_vsync, s_color} = '0;
  endtask

  task automatic ce_pulse();
    pixel_ce = 1'b1;
    tick();
    pixel_ce = 1'b0;
  endtask

  logic [13:0] prime [8];
  logic [13:0] e;
  logic [2:0]  en_pipe;
  int          cnt;
  int          peak;

  initial begin
    prime[0] = {1'b1, 1'b0, 12'h123};
    for (int i = 1; i < 8; i++) prime[i] = pix(i);

    // Reset with s_valid high: pushes must be ignored
    reset    = 1'b1;
    pixel_ce = 1'b0;
    s_valid  = 1'b1;
    s_hsync  = 1'b1;
    s_vsync  = 1'b1;
    s_color  = 12'hFFF;
    idle(3);
    check("rst_enable",    s_enable,  0);
    check("rst_out",       out_v,     0);
    check("rst_running",   running,   0);
    check("rst_underflow", underflow, 0);
    check("rst_overflow",  overflow,  0);
    reset   = 1'b0;
    s_valid = 1'b0;
    {s_hsync, s_vsync, s_color} = '0;
    tick();
    check("enable_hold_after_rst", s_enable, 0);
    tick();
    check("enable_rise", s_enable, 1);

    // Prime: 7 pixels keep FILL, 8th enters RUN one cycle later
    for (int i = 0; i < 7; i++) push_px(prime[i], 1'b0);
    check("fill_7_running", running, 0);
    ce_pulse();
    check("fill_ce_out_zero", out_v, 0);
    push_px(prime[7], 1'b0);
    check("fill_8_running", running, 0);
    tick();
    check("run_running", running, 1);
    check("run_enable",  s_enable, 1);
    for (int i = 0; i < 3; i++) begin
      ce_pulse();
      check("prime_pop", out_v, prime[i]);
      if (i == 0) begin
        check("prime_red",   vga_red,   4'h1);
        check("prime_green", vga_green, 4'h2);
        check("prime_blue",  vga_blue,  4'h3);
      end
      idle(3);
      check("prime_hold", out_v, prime[i]);
    end

    // Reset mid-operation flushes FIFO and returns to FILL
    reset   = 1'b1;
    s_valid = 1'b1;
    tick();
    reset   = 1'b0;
    s_valid = 1'b0;
    check("midrst_running", running, 0);
    check("midrst_out",     out_v,   0);
    check("midrst_enable",  s_enable, 0);
    idle(2);

    // Fill to 16 with no pops, enable ignored
    for (int i = 0; i < 16; i++) push_px(pix(i), 1'b0);
    check("full_running",  running,  1);
    check("full_enable",   s_enable, 0);
    check("full_overflow", overflow, 0);

    // Push and pop together while full
    push_px(pix(16), 1'b1);
    check("full_pushpop_out",      out_v,    pix(0));
    check("full_pushpop_overflow", overflow, 0);
    idle(3);

    // 17th entry overflows and is dropped
    push_px(pix(17), 1'b0);
    check("overflow_set", overflow, 1);

    // Drain in order; pix(17) must never appear
    for (int i = 1; i <= 16; i++) begin
      ce_pulse();
      check("drain_pop", out_v, pix(i));
      idle(3);
    end
    check("drain_no_underflow", underflow, 0);

    // Pop on empty: underflow, color 0, syncs hold from last pop
    ce_pulse();
    e = pix(16);
    check("underflow_set",   underflow, 1);
    check("underflow_out",   out_v,     {e[13:12], 12'h000});
    check("underflow_enable", s_enable, 1);
    idle(3);

    // Resume pushes
    push_px(pix(20), 1'b0);
    push_px(pix(21), 1'b0);
    ce_pulse();
    check("resume_pop0", out_v, pix(20));
    idle(3);
    ce_pulse();
    check("resume_pop1", out_v, pix(21));
    check("underflow_sticky", underflow, 1);
    check("overflow_sticky",  overflow,  1);

    // Throttle: upstream follows s_enable with 3-cycle latency, no pops
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    en_pipe = '0;
    cnt     = 0;
    peak    = 0;
    for (int c = 0; c < 30; c++) begin
      s_valid = en_pipe[2];
      s_color = 12'(c);
      tick();
      if (s_valid) cnt++;
      if (cnt > peak) peak = cnt;
      check("throttle_enable", s_enable, (c >= 1) && (cnt <= 10));
      en_pipe = {en_pipe[1:0], s_enable};
    end
    s_valid = 1'b0;
    check("throttle_peak",     peak,     13);
    check("throttle_overflow", overflow, 0);
    check("throttle_running",  running,  1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
